// File: rtl/vu_frame_scheduler.sv
// VU meter frame scheduler: tracks the per-frame audio peak, maps it onto an LED bar
// with instant attack / one-LED-per-frame decay, and hands the level to a NeoPixel driver.
module vu_frame_scheduler #(
  parameter int LEDS      = 20,
  parameter int ADDR      = 8,
  parameter int SAMPLE_W  = 16,
  parameter int FRAME_DIV = 800000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_sample_valid,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic                i_npxl_rdy,
  output logic                o_send,
  output logic [ADDR-1:0]     o_value,
  output logic                o_overrun
);
  localparam int CW = $clog2(FRAME_DIV);
  localparam int MW = SAMPLE_W - 1;
  localparam int PW = MW + $clog2(LEDS + 2);

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_WAIT_RDY, S_WAIT_ACK} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [MW-1:0]   r_acc;
  logic [MW-1:0]   r_peak;
  logic [ADDR-1:0] r_level;

  logic            w_tick;
  logic            w_neg_min;
  logic [MW-1:0]   w_abs;
  logic [MW-1:0]   w_acc_max;
  logic [PW-1:0]   w_prod;
  logic [PW-1:0]   w_scaled;
  logic [ADDR-1:0] w_target;

  assign w_tick    = (r_cnt == CW'(FRAME_DIV - 1));
  assign w_neg_min = i_sample[SAMPLE_W-1] && (i_sample[MW-1:0] == '0);

  // Magnitude fits in SAMPLE_W-1 bits once the most negative code is clamped.
  always_comb begin
    w_abs = i_sample[MW-1:0];
    if (w_neg_min)                 w_abs = '1;
    else if (i_sample[SAMPLE_W-1]) w_abs = ~i_sample[MW-1:0] + MW'(1);
  end

  assign w_acc_max = (w_abs > r_acc) ? w_abs : r_acc;
  assign w_prod    = PW'(r_peak) * PW'(LEDS + 1);
  assign w_scaled  = w_prod >> MW;
  assign w_target  = (w_scaled > PW'(LEDS)) ? ADDR'(LEDS) : w_scaled[ADDR-1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_peak    <= '0;
      r_level   <= '0;
      o_send    <= 1'b0;
      o_value   <= '0;
      o_overrun <= 1'b0;
    end else begin
      r_cnt  <= w_tick ? '0 : r_cnt + CW'(1);
      o_send <= 1'b0;

      // A sample arriving on an accepted tick starts the new frame's peak.
      if (w_tick && r_state == S_IDLE) begin
        r_peak <= r_acc;
        r_acc  <= i_sample_valid ? w_abs : '0;
      end else if (i_sample_valid) begin
        r_acc  <= w_acc_max;
      end

      if (w_tick && r_state != S_IDLE) o_overrun <= 1'b1;

      case (r_state)
        S_IDLE:     if (w_tick) r_state <= S_COMPUTE;
        S_COMPUTE: begin
          r_level <= (w_target >= r_level) ? w_target : r_level - ADDR'(1);
          r_state <= S_WAIT_RDY;
        end
        S_WAIT_RDY: if (i_npxl_rdy) begin
          o_send  <= 1'b1;
          o_value <= r_level;
          r_state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: if (!i_npxl_rdy) r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vu_frame_scheduler.sv
// Bench for vu_frame_scheduler: directed frame table, handshake/reset corners, and a
// randomized run against an event-level reference model.
module tb_vu_frame_scheduler;
  localparam int LEDS = 20;
  localparam int ADDR = 8;
  localparam int SW   = 16;
  localparam int FD   = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            sv  = 1'b0;
  logic            rdy = 1'b0;
  logic [SW-1:0]   smp = '0;
  logic            send;
  logic [ADDR-1:0] val;
  logic            ovr;

  vu_frame_scheduler #(.LEDS(LEDS), .ADDR(ADDR), .SAMPLE_W(SW), .FRAME_DIV(FD)) dut (
    .i_clk(clk), .i_rst(rst), .i_sample_valid(sv), .i_sample(smp), .i_npxl_rdy(rdy),
    .o_send(send), .o_value(val), .o_overrun(ovr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: frame-level view of peaks, levels and the pending refresh.
  int m_cnt, m_cyc, m_acc, m_lvl, m_val, m_ready_at;
  bit m_busy, m_sent, m_send, m_ovr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int mag(input logic [SW-1:0] s);
    int v;
    v = $signed(s);
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  function automatic int target(input int pk);
    longint t;
    t = (longint'(pk) * (LEDS + 1)) / 32768;
    return (t > LEDS) ? LEDS : int'(t);
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_cyc = 0; m_acc = 0; m_lvl = 0; m_val = 0; m_ready_at = 0;
    m_busy = 0; m_sent = 0; m_send = 0; m_ovr = 0;
  endtask

  task automatic model_step(input bit v, input logic [SW-1:0] s, input bit r);
    bit was_busy;
    bit tick;
    int tg;
    was_busy = m_busy;
    tick     = (m_cnt == FD - 1);
    m_send   = 0;
    if (was_busy) begin
      if (!m_sent) begin
        if (m_cyc >= m_ready_at && r) begin
          m_send = 1; m_sent = 1; m_val = m_lvl;
        end
      end else if (!r) begin
        m_busy = 0;
      end
    end
    if (tick && !was_busy) begin
      tg         = target(m_acc);
      m_lvl      = (tg >= m_lvl) ? tg : m_lvl - 1;
      m_acc      = v ? mag(s) : 0;
      m_busy     = 1;
      m_sent     = 0;
      m_ready_at = m_cyc + 2;
    end else begin
      if (tick) m_ovr = 1;
      if (v && mag(s) > m_acc) m_acc = mag(s);
    end
    m_cnt = (m_cnt + 1) % FD;
    m_cyc++;
  endtask

  task automatic step(input bit v, input logic [SW-1:0] s, input bit r);
    sv = v; smp = s; rdy = r;
    @(posedge clk);
    model_step(v, s, r);
    #1;
    check("send", send, m_send);
    check("value", val, m_val);
    check("overrun", ovr, m_ovr);
  endtask

  // One frame: sample presented, wait for the refresh, check it, then ack.
  task automatic frame(input string name, input logic [SW-1:0] s, input int exp);
    bit got;
    got = 0;
    step(1, s, 1);
    for (int i = 0; i < 40 && !got; i++) begin
      step(0, '0, 1);
      if (send === 1'b1) begin
        got = 1;
        check(name, val, exp);
      end
    end
    if (!got) check({name, " send timeout"}, 0, 1);
    step(0, '0, 0);
  endtask

  typedef struct {
    logic [SW-1:0] s;
    int            exp;
  } vec_t;

  vec_t          tbl[8];
  int            ns, lat, exp_lvl;
  bit            got;
  logic [SW-1:0] rs;
  bit            rv, rr;

  initial begin
    tbl[0] = '{16'h4000, 10};
    tbl[1] = '{16'h7FFF, 20};
    tbl[2] = '{16'h8000, 20};
    tbl[3] = '{16'h0000, 19};
    tbl[4] = '{16'h0001, 18};
    tbl[5] = '{16'h6000, 17};
    tbl[6] = '{16'h7000, 18};
    tbl[7] = '{16'hFFFF, 17};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset send", send, 0);
    check("reset value", val, 0);
    check("reset overrun", ovr, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) frame($sformatf("table[%0d]", i), tbl[i].s, tbl[i].exp);

    exp_lvl = 17;
    for (int i = 0; i < 20; i++) begin
      exp_lvl = (exp_lvl > 0) ? exp_lvl - 1 : 0;
      frame($sformatf("decay[%0d]", i), 16'h0000, exp_lvl);
    end

    // rdy low across two ticks: second tick is dropped, accumulator keeps both frames.
    ns = 0;
    for (int i = 0; i < 40; i++) begin
      step(i == 0 || i == 17 || i == 38,
           (i == 0) ? 16'h2000 : (i == 17) ? 16'h6000 : 16'h1000, 0);
      if (send === 1'b1) ns++;
    end
    check("no send while rdy low", ns, 0);
    check("overrun after dropped tick", ovr, 1);
    ns = 0; lat = -1;
    for (int i = 0; i < 10; i++) begin
      step(0, '0, 1);
      if (send === 1'b1) begin ns++; lat = val; end
    end
    check("single send after rdy", ns, 1);
    check("held-frame value", lat, 5);
    step(0, '0, 0);
    frame("retained peak", 16'h0000, 15);

    // rdy held high after a send: no further refresh until it drops.
    got = 0;
    step(1, 16'h7FFF, 1);
    for (int i = 0; i < 40 && !got; i++) begin
      step(0, '0, 1);
      if (send === 1'b1) got = 1;
    end
    check("wait-ack first send", got, 1);
    check("wait-ack first value", val, 20);
    ns = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, '0, 1);
      if (send === 1'b1) ns++;
    end
    check("no resend while rdy held", ns, 0);
    step(0, '0, 0);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(0, '0, 1);
      if (send === 1'b1) got = 1;
    end
    check("send after ack", got, 1);
    check("value after ack", val, 19);
    step(0, '0, 0);

    // Reset while a refresh is waiting for rdy.
    for (int i = 0; i < 20; i++) step(1, 16'h3000, 0);
    #2 rst = 1'b1;
    #1;
    check("async reset send", send, 0);
    check("async reset value", val, 0);
    check("async reset overrun", ovr, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    lat = 0; got = 0;
    step(1, 16'h7FFF, 1);
    lat = 1;
    if (send === 1'b1) got = 1;
    while (!got && lat < 40) begin
      step(0, '0, 1);
      lat++;
      if (send === 1'b1) got = 1;
    end
    check("first send after reset latency", lat, 18);
    check("first send after reset value", val, 20);
    step(0, '0, 0);

    for (int i = 0; i < 800; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      rs = 16'($urandom);
      if ($urandom_range(0, 1) == 1) rs = 16'($signed(rs) >>> $urandom_range(4, 15));
      if ($urandom_range(0, 19) == 0) rs = 16'h8000;
      rr = ($urandom_range(0, 9) < 7);
      step(rv, rs, rr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
